dmem_mmio: RTL and testbench

Data-side memory system for the pipelined MIPS core, directly downstream of the core's MEM stage. It decodes each data access either to a local data RAM or to a small memory-mapped I/O window. The window holds a TX byte FIFO, an RX holding register, a status register and a free-running cycle counter. Reads are combinational so that read data is valid in the same cycle the core presents the address; all state updates happen on the rising edge.

---
 rtl/dmem_mmio_pkg.sv | 17 +
 rtl/dmem_mmio_sync_fifo.sv | 55 +++++
 rtl/dmem_mmio.sv | 115 +++++++++++
 tb/tb_dmem_mmio.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-side memory system: I/O register offsets,
// STATUS bit positions and the default base of the I/O window.
package dmem_mmio_pkg;

   localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FF00;

   localparam logic [7:0] OFF_TXDATA = 8'h00;
   localparam logic [7:0] OFF_STATUS = 8'h04;
   localparam logic [7:0] OFF_RXDATA = 8'h08;
   localparam logic [7:0] OFF_CYCLE  = 8'h0C;

   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_VALID = 2;
   localparam int ST_TX_OVF   = 3;

endpackage

// File: rtl/dmem_mmio_sync_fifo.sv
// Small circular-buffer FIFO with combinational head output; head reads 0 when empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign rdata   = empty ? '0 : mem[rd_ptr_reg];

   // A push into a full buffer is still accepted when a pop frees a slot that edge.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= wdata;
   end

endmodule

// File: rtl/dmem_mmio.sv
// Data-side memory system: local RAM plus an I/O window with TX FIFO, RX holding
// register, status and free-running cycle counter. Reads are combinational.
module dmem_mmio
   import dmem_mmio_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 32,
   parameter int          RAM_AW     = 8,
   parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT,
   parameter int          TX_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  dmemread,
   input  logic                  dmemwrite,
   input  logic [ADDR_WIDTH-1:0] dadr,
   input  logic [DATA_WIDTH-1:0] dmemwd,
   output logic [DATA_WIDTH-1:0] dmemrd,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   input  logic [7:0]            rx_data_in,
   input  logic                  rx_valid_in,
   output logic                  rx_ready
);

   localparam logic [ADDR_WIDTH-1:0] IO_BASE_A = ADDR_WIDTH'(IO_BASE);

   logic [DATA_WIDTH-1:0]   ram [2**RAM_AW];
   logic [ADDR_WIDTH-1:0]   io_off;
   logic                    is_io;
   logic                    sel_tx, sel_status, sel_rx, sel_cycle;
   logic                    tx_push, tx_pop, tx_full, tx_empty;
   logic [$clog2(TX_DEPTH):0] tx_count;
   logic                    tx_ovf_reg;
   logic                    rx_valid_reg;
   logic [7:0]              rx_data_reg;
   logic [31:0]             cycle_reg;
   logic [3:0]              status_vec;
   logic [DATA_WIDTH-1:0]   io_rd;

   assign is_io      = (dadr >= IO_BASE_A);
   assign io_off     = dadr - IO_BASE_A;
   assign sel_tx     = is_io && (io_off == ADDR_WIDTH'(OFF_TXDATA));
   assign sel_status = is_io && (io_off == ADDR_WIDTH'(OFF_STATUS));
   assign sel_rx     = is_io && (io_off == ADDR_WIDTH'(OFF_RXDATA));
   assign sel_cycle  = is_io && (io_off == ADDR_WIDTH'(OFF_CYCLE));

   always_ff @(posedge clk) begin
      if (dmemwrite && !is_io) ram[dadr[RAM_AW-1:0]] <= dmemwd;
   end

   assign tx_push  = dmemwrite & sel_tx;
   assign tx_pop   = tx_valid & tx_ready;
   assign tx_valid = ~tx_empty;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (dmemwd[7:0]),
      .rdata (tx_data),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   // A dropped push outranks a same-edge clear so no overflow event is lost.
   always_ff @(posedge clk) begin
      if (reset)                                     tx_ovf_reg <= 1'b0;
      else if (tx_push && tx_full && !tx_pop)        tx_ovf_reg <= 1'b1;
      else if (dmemwrite && sel_status && dmemwd[ST_TX_OVF]) tx_ovf_reg <= 1'b0;
   end

   assign rx_ready = ~rx_valid_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_valid_reg <= 1'b0;
         rx_data_reg  <= 8'h00;
      end else if (rx_valid_in && !rx_valid_reg) begin
         rx_valid_reg <= 1'b1;
         rx_data_reg  <= rx_data_in;
      end else if (dmemread && sel_rx && rx_valid_reg) begin
         rx_valid_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) cycle_reg <= 32'h0;
      else       cycle_reg <= cycle_reg + 32'h1;
   end

   always_comb begin
      status_vec              = '0;
      status_vec[ST_TX_FULL]  = tx_full;
      status_vec[ST_TX_EMPTY] = tx_empty;
      status_vec[ST_RX_VALID] = rx_valid_reg;
      status_vec[ST_TX_OVF]   = tx_ovf_reg;
   end

   always_comb begin
      io_rd = '0;
      if (sel_status)                io_rd = DATA_WIDTH'(status_vec);
      else if (sel_rx && rx_valid_reg) io_rd = DATA_WIDTH'(rx_data_reg);
      else if (sel_cycle)            io_rd = DATA_WIDTH'(cycle_reg);
   end

   assign dmemrd = is_io ? io_rd : ram[dadr[RAM_AW-1:0]];

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio.
module tb_dmem_mmio;

   localparam logic [31:0] IOB = 32'hFFFF_FF00;

   logic        clk = 1'b0;
   logic        reset;
   logic        dmemread, dmemwrite;
   logic [31:0] dadr, dmemwd, dmemrd;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready;
   logic [7:0]  rx_data_in;
   logic        rx_valid_in, rx_ready;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   dmem_mmio dut (
      .clk         (clk),
      .reset       (reset),
      .dmemread    (dmemread),
      .dmemwrite   (dmemwrite),
      .dadr        (dadr),
      .dmemwd      (dmemwd),
      .dmemrd      (dmemrd),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data_in  (rx_data_in),
      .rx_valid_in (rx_valid_in),
      .rx_ready    (rx_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("[TB] %-14s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      dmemwrite = 1'b1;
      dadr      = a;
      dmemwd    = d;
      tick();
      dmemwrite = 1'b0;
   endtask

   // Combinational peek: strobe is dropped again before the next edge.
   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      dadr     = a;
      dmemread = 1'b1;
      #1;
      chk(tag, dmemrd, exp);
      dmemread = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] tail_bytes [3];
      tail_bytes[0] = 8'h63;
      tail_bytes[1] = 8'h64;
      tail_bytes[2] = 8'h55;

      reset = 1'b1; dmemread = 1'b0; dmemwrite = 1'b0; dadr = '0; dmemwd = '0;
      tx_ready = 1'b0; rx_data_in = 8'h00; rx_valid_in = 1'b0;
      repeat (3) tick();
      reset = 1'b0;

      // reset state and cycle counter
      chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
      chk("rst_rx_ready", {31'b0, rx_ready}, 32'h1);
      rd_chk("cycle0", IOB + 32'hC, 32'h0);
      repeat (5) tick();
      rd_chk("cycle5", IOB + 32'hC, 32'h5);
      rd_chk("rst_status", IOB + 32'h4, 32'h2);

      // RAM and decode edges
      wr(32'h11, 32'hDEADBEEF);
      wr(32'h10, 32'h12345678);
      rd_chk("ram_10", 32'h10, 32'h12345678);
      rd_chk("ram_11", 32'h11, 32'hDEADBEEF);
      wr(IOB - 32'h1, 32'hCAFEF00D);
      rd_chk("iob_m1", IOB - 32'h1, 32'hCAFEF00D);
      rd_chk("ram_ff_alias", 32'hFF, 32'hCAFEF00D);
      dadr = 32'h10; dmemread = 1'b1; dmemwrite = 1'b1; dmemwd = 32'hAAAA5555;
      #1;
      chk("rw_old", dmemrd, 32'h12345678);
      tick();
      dmemread = 1'b0; dmemwrite = 1'b0;
      rd_chk("rw_new", 32'h10, 32'hAAAA5555);
      wr(IOB + 32'h10, 32'hFFFFFFFF);
      rd_chk("unmapped", IOB + 32'h10, 32'h0);
      rd_chk("ram_10_kept", 32'h10, 32'hAAAA5555);
      rd_chk("status_kept", IOB + 32'h4, 32'h2);

      // TX with stall and overflow
      wr(IOB, 32'h41);
      chk("tx_valid_1", {31'b0, tx_valid}, 32'h1);
      wr(IOB, 32'h42);
      wr(IOB, 32'h43);
      wr(IOB, 32'h44);
      wr(IOB, 32'h45);
      rd_chk("status_ovf", IOB + 32'h4, 32'h9);
      rd_chk("txdata_rd0", IOB, 32'h0);
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("tx_drain", {24'b0, tx_data}, 32'h41 + 32'(i));
         tick();
      end
      chk("tx_drained", {31'b0, tx_valid}, 32'h0);
      rd_chk("status_empty", IOB + 32'h4, 32'hA);
      wr(IOB + 32'h4, 32'h8);
      rd_chk("ovf_cleared", IOB + 32'h4, 32'h2);
      tx_ready = 1'b0;

      // push and pop on a full FIFO
      wr(IOB, 32'h61);
      wr(IOB, 32'h62);
      wr(IOB, 32'h63);
      wr(IOB, 32'h64);
      rd_chk("status_full", IOB + 32'h4, 32'h1);
      tx_ready = 1'b1;
      dmemwrite = 1'b1; dadr = IOB; dmemwd = 32'h55;
      #1;
      chk("full_head", {24'b0, tx_data}, 32'h61);
      tick();
      dmemwrite = 1'b0;
      rd_chk("full_no_ovf", IOB + 32'h4, 32'h1);
      chk("full_next", {24'b0, tx_data}, 32'h62);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("full_tail", {24'b0, tx_data}, {24'b0, tail_bytes[i]});
      end
      tick();
      chk("full_done", {31'b0, tx_valid}, 32'h0);
      rd_chk("full_status", IOB + 32'h4, 32'h2);

      // push and pop on an empty FIFO: only the push happens
      dmemwrite = 1'b1; dadr = IOB; dmemwd = 32'h77;
      tick();
      dmemwrite = 1'b0;
      chk("empty_pp_vld", {31'b0, tx_valid}, 32'h1);
      chk("empty_pp_dat", {24'b0, tx_data}, 32'h77);
      tick();
      chk("empty_pp_pop", {31'b0, tx_valid}, 32'h0);
      tx_ready = 1'b0;

      // RX path
      rx_data_in = 8'hA5; rx_valid_in = 1'b1;
      #1;
      chk("rx_ready_pre", {31'b0, rx_ready}, 32'h1);
      tick();
      rx_data_in = 8'h5A;
      chk("rx_ready_held", {31'b0, rx_ready}, 32'h0);
      rd_chk("rx_status", IOB + 32'h4, 32'h6);
      tick();
      rx_valid_in = 1'b0;
      rd_chk("rx_peek", IOB + 32'h8, 32'hA5);
      tick();
      chk("rx_peek_kept", {31'b0, rx_ready}, 32'h0);
      dadr = IOB + 32'h8; dmemread = 1'b1;
      tick();
      dmemread = 1'b0;
      chk("rx_ready_post", {31'b0, rx_ready}, 32'h1);
      rd_chk("rx_empty_rd", IOB + 32'h8, 32'h0);

      // reset mid-transfer
      wr(IOB, 32'h01);
      wr(IOB, 32'h02);
      rx_data_in = 8'h33; rx_valid_in = 1'b1;
      tick();
      rx_valid_in = 1'b0;
      chk("pre_rst_txv", {31'b0, tx_valid}, 32'h1);
      chk("pre_rst_rxr", {31'b0, rx_ready}, 32'h0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_txv", {31'b0, tx_valid}, 32'h0);
      chk("mid_rst_txd", {24'b0, tx_data}, 32'h0);
      chk("mid_rst_rxr", {31'b0, rx_ready}, 32'h1);
      rd_chk("mid_rst_cyc", IOB + 32'hC, 32'h0);
      rd_chk("mid_rst_stat", IOB + 32'h4, 32'h2);
      tick();
      rd_chk("mid_rst_cyc1", IOB + 32'hC, 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
